// File: rtl/mem_bridge.sv
// ---------------------------------------------------------------------------
// mem_bridge
// Bridges the load/store unit of the core onto a simple valid/ready memory
// bus. One access is in flight at a time. The core is stalled while the
// access is outstanding. Load data comes back low-aligned on mem_dout.
//
// Parameters
//   XLEN        data/address width in bits (only 32 is supported)
//
// Ports
//   clk, rst_n  sole clock (rising edge), asynchronous active-low reset
//   mem_r       load request
//   mem_w       store byte strobes, low-aligned (0001 / 0011 / 1111)
//   mem_size    load width (0 byte, 1 half, 2 word)
//   mem_addr    byte address
//   mem_din     store data, low-aligned
//   mem_dout    load data, low-aligned, held until the next load completes
//   stall       holds the core while an access is outstanding
//   misalign    one-cycle misaligned-access pulse (trap build only)
//   bus_valid / bus_ready       request handshake
//   bus_we, bus_be, bus_addr, bus_wdata   request fields, lane-positioned
//   bus_rdata / bus_rvalid      read response
//
// Build option
//   MEM_BRIDGE_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses
//   are not sent to the bus; they finish in DONE with misalign=1. When it
//   is undefined, misalign is tied low and misaligned accesses are issued
//   with shifted strobes and data. Bits shifted past lane 3 are dropped.
// ---------------------------------------------------------------------------
module mem_bridge #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_r,
   input  logic [XLEN/8-1:0] mem_w,
   input  logic [1:0]        mem_size,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN-1:0]   mem_din,
   output logic [XLEN-1:0]   mem_dout,
   output logic              stall,
   output logic              misalign,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [XLEN/8-1:0] bus_be,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   input  logic [XLEN-1:0]   bus_rdata,
   input  logic              bus_rvalid
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   din_q;
   logic [XLEN/8-1:0] wstrb_q;
   logic              req_present;
   logic              is_write_q;
   logic              trap_now;

   // Any store strobe makes the access a write, even if mem_r is also high.
   assign req_present = mem_r || (mem_w != '0);
   assign is_write_q  = (wstrb_q != '0);

`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
   logic [1:0] size_q;

   // Access width comes from the strobes for stores and from mem_size for loads.
   function automatic logic is_misaligned(input logic [XLEN/8-1:0] w,
                                          input logic [1:0]        size,
                                          input logic [1:0]        a);
      logic half;
      logic word;
      if (w != '0) begin
         half = (w == (XLEN/8)'(3));
         word = (w == '1);
      end else begin
         half = (size == 2'd1);
         word = (size == 2'd2);
      end
      return (half && (a == 2'd3)) || (word && (a != 2'd0));
   endfunction

   assign trap_now = req_present && is_misaligned(mem_w, mem_size, mem_addr[1:0]);

   // A trapped access is the only way into DONE with misaligned latched
   // fields, so the pulse can be decoded from the latches.
   assign misalign = (state == DONE) && is_misaligned(wstrb_q, size_q, addr_q[1:0]);

   // The load width only matters for misalignment detection in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q <= '0;
      end else if (state == IDLE && req_present) begin
         size_q <= mem_size;
      end
   end
`else
   logic size_unused;

   assign size_unused = ^mem_size;
   assign trap_now    = 1'b0;
   assign misalign    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DONE ignores any request so the core gets one
   // unstalled cycle to retire the access before a new one can start.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_present) begin
               state_next = trap_now ? DONE : REQ;
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_next = is_write_q ? DONE : RESP;
            end
         end
         RESP: begin
            if (bus_rvalid) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are captured once in IDLE. They stay stable through
   // REQ until the bus accepts them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         din_q   <= '0;
         wstrb_q <= '0;
      end else if (state == IDLE && req_present) begin
         addr_q  <= mem_addr;
         din_q   <= mem_din;
         wstrb_q <= mem_w;
      end
   end

   // Load data is right-shifted back to low alignment. It is captured only
   // in RESP, so a stray rvalid in any other state has no effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_dout <= '0;
      end else if (state == RESP && bus_rvalid) begin
         mem_dout <= bus_rdata >> {addr_q[1:0], 3'b000};
      end
   end

   // Bus request fields. Strobes and data shifted past lane 3 are dropped.
   assign stall     = (state == IDLE && req_present) || (state == REQ) || (state == RESP);
   assign bus_valid = (state == REQ);
   assign bus_we    = (state == REQ) && is_write_q;
   assign bus_be    = is_write_q ? (wstrb_q << addr_q[1:0]) : '1;
   assign bus_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign bus_wdata = din_q << {addr_q[1:0], 3'b000};

endmodule

// File: tb/tb_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bridge
// Self-checking bench for mem_bridge. Expected bus requests go into a
// queue when each access is driven. A monitor pops one entry and compares
// it at every bus handshake. Each scenario task checks stall length,
// load data and misalign count against a reference model in this bench.
// ---------------------------------------------------------------------------
module tb_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_r = 1'b0;
   logic [3:0]  mem_w = 4'h0;
   logic [1:0]  mem_size = 2'd0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_din = 32'h0;
   logic [31:0] mem_dout;
   logic        stall;
   logic        misalign;
   logic        bus_valid;
   logic        bus_ready = 1'b0;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_rvalid = 1'b0;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_txn_t;

   int          checks = 0;
   int          errors = 0;
   bus_txn_t    exp_q[$];
   bus_txn_t    mon_e;
   logic [31:0] exp_dout = 32'h0;

   mem_bridge #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_r(mem_r), .mem_w(mem_w), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .stall(stall),
      .misalign(misalign), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_rvalid(bus_rvalid)
   );

   always #5 clk = ~clk;

   // Every accepted bus request must match the oldest expected request.
   // Write data is meaningful only for writes.
   always @(negedge clk) begin
      if (rst_n && bus_valid && bus_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL bus_unexpected: handshake addr=%h be=%b we=%b, none expected",
                     bus_addr, bus_be, bus_we);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus_addr !== mon_e.addr || bus_be !== mon_e.be || bus_we !== mon_e.we ||
                (mon_e.we && bus_wdata !== mon_e.wdata)) begin
               errors++;
               $display("[TB] FAIL bus_txn: got addr=%h be=%b we=%b wdata=%h, expected addr=%h be=%b we=%b wdata=%h",
                        bus_addr, bus_be, bus_we, bus_wdata, mon_e.addr, mon_e.be, mon_e.we, mon_e.wdata);
            end
         end
      end
   end

   // Reference model: does this access get trapped instead of issued?
   function automatic logic exp_trap(input logic [3:0] w, input logic [1:0] size,
                                     input logic [1:0] a);
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
      int nbytes;
      nbytes = (w != 4'h0) ? $countones(w) : (1 << size);
      return (nbytes == 2 && a == 2'd3) || (nbytes == 4 && a != 2'd0);
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: stalled cycles for one access.
   function automatic int exp_stall(input logic trap, input logic is_wr,
                                    input int ready_wait, input int rvalid_wait);
      if (trap) return 1;
      return 1 + (ready_wait + 1) + (is_wr ? 0 : rvalid_wait + 1);
   endfunction

   // Drives one access from IDLE and plays the bus slave. The slave
   // withholds bus_ready for ready_wait REQ cycles and bus_rvalid for
   // rvalid_wait RESP cycles. It also drives a bogus rvalid while bus_valid
   // is high. Bus fields are checked for stability across REQ. The task
   // returns when the first unstalled cycle has been sampled.
   task automatic run_access(input logic r, input logic [3:0] w, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] din,
                             input logic [31:0] rdata, input int ready_wait,
                             input int rvalid_wait, output int stall_cnt,
                             output int valid_cnt, output int mis_cnt,
                             output bus_txn_t first, output logic [31:0] dout_done);
      logic     is_wr;
      logic     trap;
      logic     accepted;
      logic     rdone;
      logic     done;
      int       resp_cnt;
      bus_txn_t cur;
      bus_txn_t e;
      is_wr     = (w != 4'h0);
      trap      = exp_trap(w, size, addr[1:0]);
      accepted  = 1'b0;
      rdone     = 1'b0;
      done      = 1'b0;
      resp_cnt  = 0;
      stall_cnt = 0;
      valid_cnt = 0;
      mis_cnt   = 0;
      first     = '0;
      dout_done = 32'h0;
      if (!trap) begin
         e.addr  = {addr[31:2], 2'b00};
         e.be    = is_wr ? 4'(w << addr[1:0]) : 4'hF;
         e.we    = is_wr;
         e.wdata = din << (8 * addr[1:0]);
         exp_q.push_back(e);
      end
      mem_r    = r;
      mem_w    = w;
      mem_size = size;
      mem_addr = addr;
      mem_din  = din;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         bus_ready = bus_valid && (valid_cnt >= ready_wait);
         if (bus_valid) begin
            bus_rvalid = 1'b1;
            bus_rdata  = ~rdata;
         end else if (accepted && !is_wr && !rdone && resp_cnt >= rvalid_wait) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rdata;
            rdone      = 1'b1;
         end else begin
            bus_rvalid = 1'b0;
            bus_rdata  = ~rdata;
         end
         @(negedge clk);
         cur = {bus_addr, bus_be, bus_we, bus_wdata};
         if (stall) stall_cnt++;
         if (misalign) mis_cnt++;
         if (bus_valid) begin
            if (valid_cnt == 0) begin
               first = cur;
            end else begin
               checks++;
               if (cur !== first) begin
                  errors++;
                  $display("[TB] FAIL bus_stable: got %h, first cycle had %h", cur, first);
               end
            end
            valid_cnt++;
            if (bus_ready) accepted = 1'b1;
         end else if (accepted) begin
            resp_cnt++;
         end
         if (!stall && cyc > 0) begin
            done      = 1'b1;
            dout_done = mem_dout;
         end
         @(posedge clk);
         #1;
         if (cyc == 0) begin
            mem_r = 1'b0;
            mem_w = 4'h0;
         end
      end
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL access_timeout: stall still %b after 40 cycles, required 0", stall);
      end
      if (!is_wr && !trap) exp_dout = rdata >> (8 * addr[1:0]);
   endtask

   // Reset values, and acceptance of a request on the first edge after release.
   task automatic test_reset();
      bus_txn_t e;
      #1;
      checks++;
      if ({bus_valid, bus_we, misalign, stall, mem_dout} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b we=%b mis=%b stall=%b dout=%h, required all 0",
                  bus_valid, bus_we, misalign, stall, mem_dout);
      end
      mem_w    = 4'hF;
      mem_addr = 32'h8;
      mem_din  = 32'h55;
      e = '{addr: 32'h8, be: 4'hF, we: 1'b1, wdata: 32'h55};
      exp_q.push_back(e);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mem_w     = 4'h0;
      bus_ready = 1'b1;
      checks++;
      if (bus_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL first_edge_accept: got bus_valid=%b, required 1", bus_valid);
      end
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Word store with bus_ready high at once.
   task automatic test_word_store();
      int sc, vc, mc;
      bus_txn_t f;
      logic [31:0] d;
      run_access(1'b0, 4'hF, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, sc, vc, mc, f, d);
      checks++;
      if (sc !== 2 || vc !== 1) begin
         errors++;
         $display("[TB] FAIL word_store_timing: got stall=%0d valid=%0d, required 2/1", sc, vc);
      end
      checks++;
      if (f !== {32'h100, 4'hF, 1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL word_store_fields: got %h, required addr=100 be=F we=1", f);
      end
      checks++;
      if (d !== exp_dout) begin
         errors++;
         $display("[TB] FAIL word_store_dout: got %h, required %h", d, exp_dout);
      end
   endtask

   // Byte store into the top lane.
   task automatic test_byte_store();
      int sc, vc, mc;
      bus_txn_t f;
      logic [31:0] d;
      run_access(1'b0, 4'h1, 2'd0, 32'h103, 32'h000000AB, 32'h0, 0, 0, sc, vc, mc, f, d);
      checks++;
      if (f !== {32'h100, 4'h8, 1'b1, 32'hAB000000} || sc !== 2) begin
         errors++;
         $display("[TB] FAIL byte_store: got fields=%h stall=%0d, required 100/8/1/AB000000 stall 2", f, sc);
      end
   endtask

   // Half load with a slow bus. Stray rvalid appears during REQ.
   task automatic test_half_load();
      int sc, vc, mc;
      bus_txn_t f;
      logic [31:0] d;
      run_access(1'b1, 4'h0, 2'd1, 32'h202, 32'h0, 32'h1234ABCD, 2, 1, sc, vc, mc, f, d);
      checks++;
      if (sc !== 6 || vc !== 3) begin
         errors++;
         $display("[TB] FAIL half_load_timing: got stall=%0d valid=%0d, required 6/3", sc, vc);
      end
      checks++;
      if (d !== 32'h00001234) begin
         errors++;
         $display("[TB] FAIL half_load_dout: got %h, required 00001234", d);
      end
      checks++;
      if (f.addr !== 32'h200 || f.be !== 4'hF || f.we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL half_load_fields: got addr=%h be=%b we=%b, required 200/1111/0", f.addr, f.be, f.we);
      end
   endtask

   // Reset while waiting in RESP. A late rvalid must be ignored afterwards.
   task automatic test_reset_in_resp();
      int sc, vc, mc;
      bus_txn_t f;
      bus_txn_t e;
      logic [31:0] d;
      e = '{addr: 32'h40, be: 4'hF, we: 1'b0, wdata: 32'h0};
      exp_q.push_back(e);
      mem_r     = 1'b1;
      mem_size  = 2'd2;
      mem_addr  = 32'h40;
      bus_ready = 1'b0;
      @(posedge clk);
      #1;
      mem_r     = 1'b0;
      bus_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
      checks++;
      if (stall !== 1'b1 || bus_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL resp_wait: got stall=%b valid=%b, required 1/0", stall, bus_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      exp_dout = 32'h0;
      checks++;
      if (bus_valid !== 1'b0 || mem_dout !== 32'h0 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_in_resp: got valid=%b dout=%h stall=%b, required 0/0/0",
                  bus_valid, mem_dout, stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hCAFEF00D;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (mem_dout !== 32'h0 || stall !== 1'b0 || bus_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_rvalid: got dout=%h stall=%b valid=%b, required 0/0/0",
                     mem_dout, stall, bus_valid);
         end
      end
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
      run_access(1'b1, 4'h0, 2'd2, 32'h44, 32'h0, 32'h11223344, 0, 0, sc, vc, mc, f, d);
      checks++;
      if (sc !== 3 || d !== 32'h11223344) begin
         errors++;
         $display("[TB] FAIL post_reset_load: got stall=%0d dout=%h, required 3/11223344", sc, d);
      end
   endtask

   // Misaligned word load and half store, plus accesses at the alignment boundaries.
   task automatic test_misalign();
      int sc, vc, mc;
      bus_txn_t f;
      logic [31:0] d;
      logic [31:0] prev;
      prev = exp_dout;
      run_access(1'b1, 4'h0, 2'd2, 32'h301, 32'h0, 32'hA1B2C3D4, 0, 0, sc, vc, mc, f, d);
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
      checks++;
      if (sc !== 1 || vc !== 0 || mc !== 1 || d !== prev) begin
         errors++;
         $display("[TB] FAIL misalign_word_load: got stall=%0d valid=%0d mis=%0d dout=%h, required 1/0/1/%h",
                  sc, vc, mc, d, prev);
      end
`else
      checks++;
      if (sc !== 3 || mc !== 0 || d !== 32'h00A1B2C3) begin
         errors++;
         $display("[TB] FAIL misalign_word_load: got stall=%0d mis=%0d dout=%h, required 3/0/00A1B2C3 (prev %h)",
                  sc, mc, d, prev);
      end
`endif
      run_access(1'b0, 4'h3, 2'd0, 32'h103, 32'h0000BEEF, 32'h0, 0, 0, sc, vc, mc, f, d);
`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
      checks++;
      if (sc !== 1 || vc !== 0 || mc !== 1) begin
         errors++;
         $display("[TB] FAIL misalign_half_store: got stall=%0d valid=%0d mis=%0d, required 1/0/1", sc, vc, mc);
      end
`else
      checks++;
      if (f !== {32'h100, 4'h8, 1'b1, 32'hEF000000} || mc !== 0) begin
         errors++;
         $display("[TB] FAIL misalign_half_store: got fields=%h mis=%0d, required 100/8/1/EF000000 mis 0", f, mc);
      end
`endif
      run_access(1'b0, 4'h3, 2'd0, 32'h102, 32'h00005678, 32'h0, 0, 0, sc, vc, mc, f, d);
      checks++;
      if (f !== {32'h100, 4'hC, 1'b1, 32'h56780000} || mc !== 0 || sc !== 2) begin
         errors++;
         $display("[TB] FAIL aligned_half_store: got fields=%h mis=%0d stall=%0d, required 100/C/1/56780000 0 2",
                  f, mc, sc);
      end
      run_access(1'b1, 4'h0, 2'd0, 32'h203, 32'h0, 32'h99887766, 1, 0, sc, vc, mc, f, d);
      checks++;
      if (d !== 32'h00000099 || mc !== 0 || sc !== 4) begin
         errors++;
         $display("[TB] FAIL byte_load_top: got dout=%h mis=%0d stall=%0d, required 00000099/0/4", d, mc, sc);
      end
   endtask

   // mem_r and mem_w together: the access must be a write.
   task automatic test_read_write_collision();
      int sc, vc, mc;
      bus_txn_t f;
      logic [31:0] d;
      logic [31:0] prev;
      prev = exp_dout;
      run_access(1'b1, 4'h3, 2'd1, 32'h10, 32'h0000CAFE, 32'h13572468, 0, 0, sc, vc, mc, f, d);
      checks++;
      if (f !== {32'h10, 4'h3, 1'b1, 32'h0000CAFE} || d !== prev || sc !== 2) begin
         errors++;
         $display("[TB] FAIL rw_collision: got fields=%h dout=%h stall=%0d, required 10/3/1/0000CAFE dout %h stall 2",
                  f, d, sc, prev);
      end
   endtask

   // A string of random accesses with random bus delays, run back to back.
   task automatic test_back_to_back();
      int sc, vc, mc;
      bus_txn_t f;
      logic [31:0] d;
      logic [31:0] a;
      logic [31:0] din;
      logic [31:0] rd;
      logic [3:0]  w;
      logic [1:0]  sz;
      logic        tr;
      int          rw, vw;
      for (int i = 0; i < 8; i++) begin
         a   = 32'h400 + $urandom_range(0, 63);
         din = $urandom;
         rd  = $urandom;
         rw  = $urandom_range(0, 2);
         vw  = $urandom_range(0, 2);
         sz  = 2'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0:       w = 4'h1;
            1:       w = 4'h3;
            2:       w = 4'hF;
            default: w = 4'h0;
         endcase
         tr = exp_trap(w, sz, a[1:0]);
         run_access(w == 4'h0, w, sz, a, din, rd, rw, vw, sc, vc, mc, f, d);
         checks++;
         if (sc !== exp_stall(tr, w != 4'h0, rw, vw) || d !== exp_dout || mc !== int'(tr)) begin
            errors++;
            $display("[TB] FAIL b2b_%0d: got stall=%0d dout=%h mis=%0d, required stall=%0d dout=%h mis=%0d",
                     i, sc, d, mc, exp_stall(tr, w != 4'h0, rw, vw), exp_dout, tr);
         end
      end
   endtask

   initial begin
      $display("[TB] mem_bridge bench start");
      test_reset();
      test_word_store();
      test_byte_store();
      test_half_load();
      test_reset_in_resp();
      test_misalign();
      test_read_write_collision();
      test_back_to_back();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d expected requests never issued, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
